// File: rtl/function_arith_pkg.sv
// Shared types for the pipelined arith block: per-transaction mode encoding.
package function_arith_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        PLAIN = 2'd0,
        ACC   = 2'd1,
        NOXOR = 2'd2,
        RSVD  = 2'd3
    } mode_e;

endpackage

// File: rtl/function_arith_stage_reg.sv
// Enable-gated pipeline register carrying a valid bit and an opaque payload.
module function_arith_stage_reg #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          vld_i,
    input  logic [PW-1:0] data_i,
    output logic          vld_o,
    output logic [PW-1:0] data_o
);

    logic          vld_q;
    logic [PW-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (en_i) begin
            vld_q  <= vld_i;
            data_q <= data_i;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/function_arith_pipe.sv
// Three-stage r = (((x+y)-z) << SHIFT | (x&y)) ^ z with valid/ready backpressure,
// accumulate / no-xor modes and a completed-handshake counter.
module function_arith_pipe
    import function_arith_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHIFT   = 1,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH-1:0]   in_c,
    input  logic [MODE_W-1:0]  in_mode,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [COUNT_W-1:0] out_count
);

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] z;
        mode_e            mode;
    } st1_t;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] z;
        mode_e            mode;
    } st2_t;

    logic adv;
    logic v1, v2, v3;
    st1_t st1_d, st1_q;
    st2_t st2_d, st2_q;
    logic [WIDTH-1:0] res_d, res_q;
    logic [WIDTH-1:0] diff, base, xored, acc_eff, acc_sum;
    logic [WIDTH-1:0] acc_d, acc_q;
    logic [COUNT_W-1:0] cnt_d, cnt_q;
    logic acc_load;

    // The whole pipe moves as one; a held result freezes every stage.
    assign adv      = !v3 || out_ready;
    assign in_ready = adv;

    always_comb begin
        st1_d      = '0;
        st1_d.s    = in_a + in_b;
        st1_d.m    = in_a & in_b;
        st1_d.z    = in_c;
        st1_d.mode = mode_e'(in_mode);
    end

    always_comb begin
        diff       = st1_q.s - st1_q.z;
        st2_d      = '0;
        st2_d.d    = diff << SHIFT;
        st2_d.m    = st1_q.m;
        st2_d.z    = st1_q.z;
        st2_d.mode = st1_q.mode;
    end

    always_comb begin
        base    = st2_q.d | st2_q.m;
        xored   = base ^ st2_q.z;
        acc_eff = acc_clr ? '0 : acc_q;
        acc_sum = xored + acc_eff;
        case (st2_q.mode)
            ACC:     res_d = acc_sum;
            NOXOR:   res_d = base;
            default: res_d = xored;
        endcase
    end

    // Only a real ACC beat entering the output stage updates acc; bubbles never do.
    assign acc_load = adv && v2 && (st2_q.mode == ACC);

    always_comb begin
        acc_d = acc_q;
        if (acc_load)
            acc_d = acc_sum;
        else if (adv && acc_clr)
            acc_d = '0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (v3 && out_ready)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    function_arith_stage_reg #(.PW($bits(st1_t))) u_st1 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (adv),
        .vld_i  (in_valid),
        .data_i (st1_d),
        .vld_o  (v1),
        .data_o (st1_q)
    );

    function_arith_stage_reg #(.PW($bits(st2_t))) u_st2 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (adv),
        .vld_i  (v1),
        .data_i (st2_d),
        .vld_o  (v2),
        .data_o (st2_q)
    );

    function_arith_stage_reg #(.PW(WIDTH)) u_st3 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (adv),
        .vld_i  (v2),
        .data_i (res_d),
        .vld_o  (v3),
        .data_o (res_q)
    );

    assign out_valid = v3;
    assign out_data  = res_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_function_arith_pipe.sv
// Directed + random bench for function_arith_pipe against a transaction-level model.
module tb_function_arith_pipe;

    localparam int W  = 8;
    localparam int SH = 1;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b, in_c;
    logic [1:0]    in_mode;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;

    int errs = 0;
    int checks = 0;

    // model: beats in flight, each slot holding raw operands; slot 3 holds the result
    bit            mv[1:3];
    logic [W-1:0]  ma[1:2], mb[1:2], mc[1:2];
    logic [1:0]    mm[1:2];
    logic [W-1:0]  mout;
    logic [W-1:0]  macc;
    logic [CW-1:0] mcnt;

    logic [W-1:0]  held;
    int            accepted;
    logic [CW-1:0] cnt0;

    function_arith_pipe #(.WIDTH(W), .SHIFT(SH), .COUNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_mode   (in_mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] formula(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] z, input logic [1:0] mode,
                                             input logic clr, inout logic [W-1:0] acc);
        logic [W-1:0] sum, dif, sft, base, r;
        sum  = x + y;
        dif  = sum - z;
        sft  = dif << SH;
        base = sft | (x & y);
        if (mode == 2'd2) r = base;
        else              r = base ^ z;
        if (mode == 2'd1) begin
            r   = r + (clr ? '0 : acc);
            acc = r;
        end else if (clr) begin
            acc = '0;
        end
        return r;
    endfunction

    // advance the model by one clock with current inputs, then check outputs #1 after the edge
    task automatic tick();
        bit madv;
        madv = !mv[3] || out_ready;
        if (rst) begin
            mv[1] = 0; mv[2] = 0; mv[3] = 0;
            mout = '0; macc = '0; mcnt = '0;
        end else begin
            if (mv[3] && out_ready) mcnt = mcnt + 1'b1;
            if (madv) begin
                if (mv[2])
                    mout = formula(ma[2], mb[2], mc[2], mm[2], acc_clr, macc);
                else if (acc_clr)
                    macc = '0;
                mv[3] = mv[2];
                mv[2] = mv[1]; ma[2] = ma[1]; mb[2] = mb[1]; mc[2] = mc[1]; mm[2] = mm[1];
                mv[1] = in_valid; ma[1] = in_a; mb[1] = in_b; mc[1] = in_c; mm[1] = in_mode;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(mv[3]));
        chk("in_ready", 32'(in_ready), 32'(!mv[3] || out_ready));
        chk("out_count", 32'(out_count), 32'(mcnt));
        if (mv[3]) chk("out_data", 32'(out_data), 32'(mout));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [1:0] mode);
        in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_mode = mode;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0; in_mode = '0;
        acc_clr = 1'b0; out_ready = 1'b1;
        mv[1] = 0; mv[2] = 0; mv[3] = 0; mout = '0; macc = '0; mcnt = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_count", 32'(out_count), 0);

        // basic
        send(5, 3, 2, 2'd0); idle(); idle();
        chk("basic_valid", 32'(out_valid), 1);
        chk("basic_data", 32'(out_data), 15);
        idle();
        chk("basic_count", 32'(out_count), 1);

        // wrap / underflow back-to-back
        send(200, 100, 10, 2'd0); send(0, 0, 1, 2'd0); idle();
        chk("wrap_data", 32'(out_data), 78);
        idle();
        chk("underflow_data", 32'(out_data), 255);
        idle();

        // modes
        send(5, 3, 2, 2'd2); idle(); idle();
        chk("noxor_data", 32'(out_data), 13);
        send(5, 3, 2, 2'd1); send(5, 3, 2, 2'd1); idle();
        chk("acc1_data", 32'(out_data), 15);
        idle();
        chk("acc2_data", 32'(out_data), 30);
        idle();
        acc_clr = 1'b1; idle(); acc_clr = 1'b0;
        send(5, 3, 2, 2'd1); idle(); idle();
        chk("acc_after_clr", 32'(out_data), 15);
        send(5, 3, 2, 2'd1); idle();
        acc_clr = 1'b1; idle(); acc_clr = 1'b0;
        chk("acc_clr_coincident", 32'(out_data), 15);
        send(5, 3, 2, 2'd1); idle(); idle();
        chk("acc_after_coincident", 32'(out_data), 30);
        idle(); idle();

        // backpressure
        out_ready = 1'b0;
        accepted = 0;
        cnt0 = out_count;
        for (int k = 0; k < 3; k++) begin
            send(8'(10 + k), 8'(20 + k), 8'(k), 2'd0);
            accepted++;
        end
        chk("bp_in_ready_low", 32'(in_ready), 0);
        held = out_data;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_a = 8'd13; in_b = 8'd23; in_c = 8'd3; in_mode = 2'd0;
            tick();
            chk("bp_stable", 32'(out_data), 32'(held));
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10 && accepted < 4; k++) begin
            if (!mv[3] || out_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) idle();
        chk("bp_count", 32'(out_count - cnt0), 4);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_c      = 8'($urandom);
            in_mode   = 2'($urandom);
            acc_clr   = 1'($urandom_range(0, 9) == 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        acc_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) idle();

        // reset mid-flight
        send(5, 3, 2, 2'd1); send(7, 1, 4, 2'd0);
        rst = 1'b1; in_valid = 1'b1; tick(); rst = 1'b0; in_valid = 1'b0;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_data", 32'(out_data), 0);
        chk("midrst_count", 32'(out_count), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("midrst_no_stale", 32'(out_valid), 0);
        end
        send(5, 3, 2, 2'd1); idle(); idle();
        chk("midrst_acc_zero", 32'(out_data), 15);
        idle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
